data_cache_axi_master: RTL

AXI4 burst master serving the data cache controller's memory-side requests. It converts the controller's level-held `i_start_read` / `i_start_write` requests into single-outstanding AXI4 INCR bursts of one cache block. On reads it assembles the returned beats into a block buffer and pulses `o_r_last`. On writes it streams the victim block out and pulses `o_b_resp` after the write response. It sits directly downstream of the data cache FSM and upstream of the SoC interconnect.

---
 rtl/data_cache_axi_master_if.sv | 36 +++
 rtl/data_cache_axi_master.sv | 87 ++++++++
 2 files changed

// File: rtl/data_cache_axi_master_if.sv
// data_cache_axi_master_if: AXI4 AR/R/AW/W/B channels between the cache burst master and the interconnect
interface data_cache_axi_master_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 32
);
    logic                    o_arvalid, i_arready;
    logic [ADDR_WIDTH-1:0]   o_araddr;
    logic [7:0]              o_arlen;
    logic [2:0]              o_arsize;
    logic [1:0]              o_arburst;
    logic                    i_rvalid, o_rready, i_rlast;
    logic [DATA_WIDTH-1:0]   i_rdata;
    logic [1:0]              i_rresp;
    logic                    o_awvalid, i_awready;
    logic [ADDR_WIDTH-1:0]   o_awaddr;
    logic [7:0]              o_awlen;
    logic [2:0]              o_awsize;
    logic [1:0]              o_awburst;
    logic                    o_wvalid, i_wready, o_wlast;
    logic [DATA_WIDTH-1:0]   o_wdata;
    logic [DATA_WIDTH/8-1:0] o_wstrb;
    logic                    i_bvalid, o_bready;
    logic [1:0]              i_bresp;
    modport master (
        output o_arvalid, o_araddr, o_arlen, o_arsize, o_arburst, o_rready,
               o_awvalid, o_awaddr, o_awlen, o_awsize, o_awburst,
               o_wvalid, o_wdata, o_wstrb, o_wlast, o_bready,
        input  i_arready, i_rvalid, i_rdata, i_rresp, i_rlast, i_awready, i_wready, i_bvalid, i_bresp
    );
    modport slave (
        input  o_arvalid, o_araddr, o_arlen, o_arsize, o_arburst, o_rready,
               o_awvalid, o_awaddr, o_awlen, o_awsize, o_awburst,
               o_wvalid, o_wdata, o_wstrb, o_wlast, o_bready,
        output i_arready, i_rvalid, i_rdata, i_rresp, i_rlast, i_awready, i_wready, i_bvalid, i_bresp
    );
endinterface

// File: rtl/data_cache_axi_master.sv
// data_cache_axi_master: single-outstanding AXI4 INCR block burst master for the data cache fill/write-back path
module data_cache_axi_master #(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 32,
    parameter int BLOCK_WORDS = 16
) (
    input  logic                              clk,
    input  logic                              arst,
    input  logic                              i_start_read,
    input  logic                              i_start_write,
    input  logic [ADDR_WIDTH-1:0]             i_addr,
    input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] i_wr_block,
    output logic [BLOCK_WORDS*DATA_WIDTH-1:0] o_rd_block,
    output logic                              o_r_last,
    output logic                              o_b_resp,
    output logic                              o_resp_err,
    data_cache_axi_master_if.master           axi
);
    localparam int CW  = $clog2(BLOCK_WORDS);
    localparam int OFF = $clog2(BLOCK_WORDS*DATA_WIDTH/8);
    typedef enum logic [2:0] {IDLE, AR, R, R_DONE, AW, W, B, B_DONE} state_t;
    state_t                state;
    logic [CW-1:0]         beat_cnt, nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    assign nxt           = beat_cnt + 1'b1;
    assign axi.o_araddr  = addr_q;
    assign axi.o_awaddr  = addr_q;
    assign axi.o_arlen   = 8'(BLOCK_WORDS-1);
    assign axi.o_awlen   = 8'(BLOCK_WORDS-1);
    assign axi.o_arsize  = 3'($clog2(DATA_WIDTH/8));
    assign axi.o_awsize  = 3'($clog2(DATA_WIDTH/8));
    assign axi.o_arburst = 2'b01;
    assign axi.o_awburst = 2'b01;
    assign axi.o_wstrb   = {(DATA_WIDTH/8){1'b1}};
    assign axi.o_arvalid = state == AR;
    assign axi.o_rready  = state == R;
    assign axi.o_awvalid = state == AW;
    assign axi.o_wvalid  = state == W;
    assign axi.o_bready  = state == B;
    assign o_r_last      = state == R_DONE;
    assign o_b_resp      = state == B_DONE;
    // o_wdata/o_wlast are preloaded one beat ahead so W carries no path from i_wr_block
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            addr_q      <= '0;
            o_rd_block  <= '0;
            o_resp_err  <= 1'b0;
            axi.o_wdata <= '0;
            axi.o_wlast <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_start_write || i_start_read) begin
                    state      <= i_start_write ? AW : AR;
                    addr_q     <= (i_addr >> OFF) << OFF;
                    o_resp_err <= 1'b0;
                    beat_cnt   <= '0;
                end
                AR: if (axi.i_arready) state <= R;
                R: if (axi.i_rvalid) begin
                    o_rd_block[beat_cnt*DATA_WIDTH +: DATA_WIDTH] <= axi.i_rdata;
                    beat_cnt <= nxt;
                    if (axi.i_rresp != 2'b00 || axi.i_rlast != &beat_cnt) o_resp_err <= 1'b1;
                    if (&beat_cnt) state <= R_DONE;
                end
                R_DONE: state <= IDLE;
                AW: if (axi.i_awready) begin
                    state       <= W;
                    axi.o_wdata <= i_wr_block[0 +: DATA_WIDTH];
                    axi.o_wlast <= 1'b0;
                end
                W: if (axi.i_wready) begin
                    beat_cnt    <= nxt;
                    axi.o_wdata <= i_wr_block[nxt*DATA_WIDTH +: DATA_WIDTH];
                    axi.o_wlast <= &nxt;
                    if (&beat_cnt) state <= B;
                end
                B: if (axi.i_bvalid) begin
                    if (axi.i_bresp != 2'b00) o_resp_err <= 1'b1;
                    state <= B_DONE;
                end
                B_DONE: state <= IDLE;
            endcase
        end
    end
endmodule
